sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port between two requesters: instruction fetch (port I) and the EXE-stage load/store interface (port D).
- Requesters use the req/addr_ok/data_ok protocol. The downstream port (port M) feeds the cache/AXI bridge.
- Arbitrates address phases, holds the downstream request stable until accepted, and routes in-order responses back to the issuing requester through an ID FIFO.

---
 rtl/sram_bus_arbiter_pkg.sv | 25 ++
 rtl/sram_bus_arbiter_if.sv | 27 ++
 rtl/sram_id_fifo.sv | 67 ++++++
 rtl/sram_bus_arbiter.sv | 103 ++++++++++
 tb/tb_sram_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_bus_arbiter_pkg : shared IDs, size encodings and lock states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sram_bus_arbiter_pkg;

    typedef logic req_id_t;

    localparam req_id_t REQ_ID_INST = 1'b0;
    localparam req_id_t REQ_ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int OUTSTANDING_DEFAULT = 4;

    typedef enum logic [0:0] {
        LOCK_FREE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_bus_arbiter_if : one SRAM-like req/addr_ok/data_ok channel.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sram_bus_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_id_fifo : synchronous FIFO with combinational head, WIDTH x DEPTH.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sram_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic      [PTR_W:0]   count,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_bus_arbiter : shares one SRAM-like port between fetch and LSU.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEFAULT,
    parameter int PTR_W       = $clog2(OUTSTANDING)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    sram_bus_arbiter_if.slave  i_port,
    sram_bus_arbiter_if.slave  d_port,
    sram_bus_arbiter_if.master m_port,
    output logic [PTR_W:0]     outstanding_cnt,
    output logic               resp_err
);

    lock_state_e lock_state_q, lock_state_d;
    req_id_t     lock_id_q, lock_id_d;
    logic        resp_err_q, resp_err_d;

    logic        grant_i, grant_d, m_req;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    req_id_t     push_id, head_id;
    logic        lock_active;

    // The fetch port never writes; its write fields are intentionally ignored.
    logic unused_i_fields;
    assign unused_i_fields = ^{i_port.wr, i_port.wstrb, i_port.wdata};

    always_comb begin
        lock_active = (lock_state_q == LOCK_HELD);
        grant_d = ~reset & d_port.req & ~fifo_full
                & (~lock_active | (lock_id_q == REQ_ID_DATA));
        grant_i = ~reset & i_port.req & ~fifo_full & ~grant_d
                & (~lock_active | (lock_id_q == REQ_ID_INST));
        m_req   = grant_d | grant_i;

        push_id   = grant_d ? REQ_ID_DATA : REQ_ID_INST;
        fifo_push = m_req & m_port.addr_ok;
        fifo_pop  = ~reset & m_port.data_ok & ~fifo_empty;
    end

    // Lock holds the downstream request stable until the address is accepted.
    // A dropped request also drops m_req, which releases the lock here.
    always_comb begin
        lock_state_d = LOCK_FREE;
        lock_id_d    = lock_id_q;
        resp_err_d   = resp_err_q | (m_port.data_ok & fifo_empty);
        if (m_req && !m_port.addr_ok) begin
            lock_state_d = LOCK_HELD;
            lock_id_d    = push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_state_q <= LOCK_FREE;
            lock_id_q    <= REQ_ID_INST;
            resp_err_q   <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_id_q    <= lock_id_d;
            resp_err_q   <= resp_err_d;
        end
    end

    sram_id_fifo #(
        .WIDTH (1),
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_id),
        .pop   (fifo_pop),
        .head  (head_id),
        .count (outstanding_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_port.req   = m_req;
    assign m_port.wr    = grant_d & d_port.wr;
    assign m_port.size  = grant_d ? d_port.size  : (grant_i ? i_port.size : 2'b00);
    assign m_port.wstrb = grant_d ? d_port.wstrb : 4'b0000;
    assign m_port.addr  = grant_d ? d_port.addr  : (grant_i ? i_port.addr : 32'h0);
    assign m_port.wdata = grant_d ? d_port.wdata : 32'h0;

    assign i_port.addr_ok = grant_i & m_port.addr_ok;
    assign d_port.addr_ok = grant_d & m_port.addr_ok;
    assign i_port.data_ok = fifo_pop & (head_id == REQ_ID_INST);
    assign d_port.data_ok = fifo_pop & (head_id == REQ_ID_DATA);
    assign i_port.rdata   = m_port.rdata;
    assign d_port.rdata   = m_port.rdata;

    assign resp_err = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram_bus_arbiter : directed self-checking bench for the arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sram_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] outstanding_cnt;
    logic       resp_err;
    int         checks = 0;
    int         failures = 0;

    sram_bus_arbiter_if i_bus ();
    sram_bus_arbiter_if d_bus ();
    sram_bus_arbiter_if m_bus ();

    sram_bus_arbiter #(.OUTSTANDING(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_port          (i_bus),
        .d_port          (d_bus),
        .m_port          (m_bus),
        .outstanding_cnt (outstanding_cnt),
        .resp_err        (resp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_bus.req = 0; i_bus.wr = 0; i_bus.size = 2'd2; i_bus.wstrb = 0;
        i_bus.addr = 0; i_bus.wdata = 0;
        d_bus.req = 0; d_bus.wr = 0; d_bus.size = 2'd2; d_bus.wstrb = 0;
        d_bus.addr = 0; d_bus.wdata = 0;
        m_bus.addr_ok = 0; m_bus.data_ok = 0; m_bus.rdata = 0;
    endtask

    initial begin
        // Reset, with requests present that must be masked.
        idle();
        reset = 1; i_bus.req = 1; d_bus.req = 1; m_bus.addr_ok = 1; m_bus.data_ok = 1;
        settle();
        chk("rst_m_req", 32'(m_bus.req), 0);
        chk("rst_i_addr_ok", 32'(i_bus.addr_ok), 0);
        chk("rst_d_addr_ok", 32'(d_bus.addr_ok), 0);
        chk("rst_d_data_ok", 32'(d_bus.data_ok), 0);
        tick();
        reset = 0; idle();
        settle();
        chk("rst_cnt", 32'(outstanding_cnt), 0);
        chk("rst_err", 32'(resp_err), 0);

        // Instruction read.
        tick();
        i_bus.req = 1; i_bus.addr = 32'h1C000000; m_bus.addr_ok = 1;
        settle();
        chk("ird_addr_ok", 32'(i_bus.addr_ok), 1);
        chk("ird_m_addr", m_bus.addr, 32'h1C000000);
        chk("ird_m_wr", 32'(m_bus.wr), 0);
        tick();
        idle();
        settle();
        chk("ird_cnt1", 32'(outstanding_cnt), 1);
        chk("ird_m_req_idle", 32'(m_bus.req), 0);
        tick();
        m_bus.data_ok = 1; m_bus.rdata = 32'h02800C0C;
        settle();
        chk("ird_data_ok", 32'(i_bus.data_ok), 1);
        chk("ird_rdata", i_bus.rdata, 32'h02800C0C);
        chk("ird_d_data_ok", 32'(d_bus.data_ok), 0);
        tick();
        idle();
        settle();
        chk("ird_cnt0", 32'(outstanding_cnt), 0);

        // Contention: D store wins, I follows; responses D then I.
        tick();
        i_bus.req = 1; i_bus.addr = 32'h100;
        d_bus.req = 1; d_bus.wr = 1; d_bus.addr = 32'h8; d_bus.wstrb = 4'hF;
        d_bus.wdata = 32'hDEADBEEF; m_bus.addr_ok = 1;
        settle();
        chk("con_m_wr", 32'(m_bus.wr), 1);
        chk("con_m_addr", m_bus.addr, 32'h8);
        chk("con_m_wstrb", 32'(m_bus.wstrb), 32'hF);
        chk("con_m_wdata", m_bus.wdata, 32'hDEADBEEF);
        chk("con_d_addr_ok", 32'(d_bus.addr_ok), 1);
        chk("con_i_addr_ok0", 32'(i_bus.addr_ok), 0);
        tick();
        d_bus.req = 0;
        settle();
        chk("con_i_addr_ok1", 32'(i_bus.addr_ok), 1);
        chk("con_i_m_addr", m_bus.addr, 32'h100);
        chk("con_i_m_wr", 32'(m_bus.wr), 0);
        chk("con_i_m_wstrb", 32'(m_bus.wstrb), 0);
        tick();
        idle();
        m_bus.data_ok = 1; m_bus.rdata = 32'h11111111;
        settle();
        chk("con_cnt2", 32'(outstanding_cnt), 2);
        chk("con_rsp1_d", 32'(d_bus.data_ok), 1);
        chk("con_rsp1_i", 32'(i_bus.data_ok), 0);
        tick();
        m_bus.rdata = 32'h22222222;
        settle();
        chk("con_rsp2_i", 32'(i_bus.data_ok), 1);
        chk("con_rsp2_d", 32'(d_bus.data_ok), 0);
        chk("con_rsp2_rdata", i_bus.rdata, 32'h22222222);
        tick();
        idle();
        settle();
        chk("con_cnt0", 32'(outstanding_cnt), 0);

        // Lock: I held for 3 cycles, D arrives in cycle 1 and must wait.
        tick();
        i_bus.req = 1; i_bus.addr = 32'h200;
        settle();
        chk("lck_c0_m_addr", m_bus.addr, 32'h200);
        tick();
        d_bus.req = 1; d_bus.addr = 32'h300;
        settle();
        chk("lck_c1_m_addr", m_bus.addr, 32'h200);
        tick();
        settle();
        chk("lck_c2_m_addr", m_bus.addr, 32'h200);
        tick();
        m_bus.addr_ok = 1;
        settle();
        chk("lck_c3_m_addr", m_bus.addr, 32'h200);
        chk("lck_c3_i_addr_ok", 32'(i_bus.addr_ok), 1);
        chk("lck_c3_d_addr_ok", 32'(d_bus.addr_ok), 0);
        tick();
        i_bus.req = 0;
        settle();
        chk("lck_c4_m_addr", m_bus.addr, 32'h300);
        chk("lck_c4_d_addr_ok", 32'(d_bus.addr_ok), 1);
        tick();
        idle();
        m_bus.data_ok = 1;
        settle();
        chk("lck_rsp_i", 32'(i_bus.data_ok), 1);
        tick();
        settle();
        chk("lck_rsp_d", 32'(d_bus.data_ok), 1);
        tick();
        idle();

        // Locked requester drops its request: lock must release.
        i_bus.req = 1; i_bus.addr = 32'h400;
        settle();
        chk("drp_m_req0", 32'(m_bus.req), 1);
        tick();
        i_bus.req = 0; d_bus.req = 1; d_bus.addr = 32'h500;
        settle();
        chk("drp_m_req1", 32'(m_bus.req), 0);
        tick();
        m_bus.addr_ok = 1;
        settle();
        chk("drp_d_addr_ok", 32'(d_bus.addr_ok), 1);
        chk("drp_m_addr", m_bus.addr, 32'h500);
        tick();
        idle();
        m_bus.data_ok = 1;
        settle();
        chk("drp_rsp_d", 32'(d_bus.data_ok), 1);
        tick();
        idle();

        // Back-pressure: four D loads fill the FIFO; pointers wrap here.
        for (int k = 0; k < 4; k++) begin
            d_bus.req = 1; d_bus.addr = 32'h1000 + 32'(k * 4); m_bus.addr_ok = 1;
            settle();
            chk("bp_fill_addr_ok", 32'(d_bus.addr_ok), 1);
            tick();
        end
        settle();
        chk("bp_cnt4", 32'(outstanding_cnt), 4);
        chk("bp_full_m_req", 32'(m_bus.req), 0);
        chk("bp_full_addr_ok", 32'(d_bus.addr_ok), 0);
        tick();
        d_bus.req = 0; m_bus.data_ok = 1;
        settle();
        chk("bp_popA_d", 32'(d_bus.data_ok), 1);
        tick();
        i_bus.req = 1; i_bus.addr = 32'h600;
        settle();
        chk("bp_pushpop_i_addr_ok", 32'(i_bus.addr_ok), 1);
        chk("bp_pushpop_d_data_ok", 32'(d_bus.data_ok), 1);
        chk("bp_cnt3a", 32'(outstanding_cnt), 3);
        tick();
        i_bus.req = 0; m_bus.addr_ok = 0;
        settle();
        chk("bp_cnt3b", 32'(outstanding_cnt), 3);
        chk("bp_popC_d", 32'(d_bus.data_ok), 1);
        tick();
        settle();
        chk("bp_popD_d", 32'(d_bus.data_ok), 1);
        chk("bp_popD_i", 32'(i_bus.data_ok), 0);
        tick();
        settle();
        chk("bp_popE_i", 32'(i_bus.data_ok), 1);
        chk("bp_popE_d", 32'(d_bus.data_ok), 0);
        tick();
        idle();
        settle();
        chk("bp_cnt0", 32'(outstanding_cnt), 0);
        chk("bp_err_clear", 32'(resp_err), 0);

        // Stray response with empty FIFO.
        tick();
        m_bus.data_ok = 1; m_bus.rdata = 32'hCAFEF00D;
        settle();
        chk("str_i_data_ok", 32'(i_bus.data_ok), 0);
        chk("str_d_data_ok", 32'(d_bus.data_ok), 0);
        tick();
        idle();
        settle();
        chk("str_err_set", 32'(resp_err), 1);
        chk("str_cnt", 32'(outstanding_cnt), 0);
        tick();
        settle();
        chk("str_err_held", 32'(resp_err), 1);

        // Reset mid-flight with two outstanding.
        tick();
        i_bus.req = 1; m_bus.addr_ok = 1;
        tick();
        tick();
        idle();
        settle();
        chk("mid_cnt2", 32'(outstanding_cnt), 2);
        tick();
        reset = 1; d_bus.req = 1; m_bus.addr_ok = 1; m_bus.data_ok = 1;
        settle();
        chk("mid_m_req", 32'(m_bus.req), 0);
        chk("mid_d_addr_ok", 32'(d_bus.addr_ok), 0);
        chk("mid_data_ok", 32'({i_bus.data_ok, d_bus.data_ok}), 0);
        tick();
        reset = 0; idle();
        settle();
        chk("mid_cnt0", 32'(outstanding_cnt), 0);
        chk("mid_err0", 32'(resp_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
